// File: rtl/cam_entry_loader.sv
// Collects multi-beat CAM key configuration and issues one guarded CAM write per entry.
// Optional CAM_ENTRY_LOADER_STATS_EN adds saturating write/error counters.
module cam_entry_loader #(
    parameter int C_WIDTH   = 205,
    parameter int ADDR_BITS = 4,
    parameter int CFG_W     = 64
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [CFG_W-1:0]     s_data,
    input  logic [ADDR_BITS-1:0] s_addr,
    input  logic                 s_last,
    output logic                 cam_we,
    output logic [ADDR_BITS-1:0] cam_wr_addr,
    output logic [C_WIDTH-1:0]   cam_din,
    input  logic                 cam_busy,
    output logic                 err_pulse,
    output logic                 idle
`ifdef CAM_ENTRY_LOADER_STATS_EN
    ,
    output logic [15:0]          stat_writes,
    output logic [15:0]          stat_errors
`endif
);

    localparam int BEATS = (C_WIDTH + CFG_W - 1) / CFG_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int KW    = BEATS * CFG_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_ISSUE, S_GUARD} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [C_WIDTH-1:0]     key_q, key_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [C_WIDTH-1:0]     din_q, din_d;
    logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic                   err_q, err_d;
    logic                   we_c;
    logic                   beat;
    logic [KW-1:0]          kbuf;
    int unsigned            slice_lo;

    assign s_ready     = aresetn && (state_q == S_COLLECT || state_q == S_DRAIN);
    assign beat        = s_valid && s_ready;
    assign cam_we      = we_c;
    assign cam_wr_addr = wr_addr_q;
    assign cam_din     = din_q;
    assign err_pulse   = err_q;
    assign idle        = (state_q == S_COLLECT) && (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        addr_d    = addr_q;
        din_d     = din_q;
        wr_addr_d = wr_addr_q;
        err_d     = 1'b0;
        we_c      = 1'b0;
        kbuf      = KW'(key_q);
        slice_lo  = 32'(cnt_q) * 32'(CFG_W);
        case (state_q)
            S_COLLECT: if (beat) begin
                // Wide scratch buffer lets the top beat spill past C_WIDTH harmlessly.
                kbuf[slice_lo +: CFG_W] = s_data;
                key_d = kbuf[C_WIDTH-1:0];
                if (cnt_q == '0) addr_d = s_addr;
                if (s_last) begin
                    cnt_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d   = S_ISSUE;
                        din_d     = key_d;
                        wr_addr_d = addr_d;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: if (beat && s_last) begin
                err_d   = 1'b1;
                state_d = S_COLLECT;
                cnt_d   = '0;
            end
            S_ISSUE: if (!cam_busy) begin
                we_c    = 1'b1;
                state_d = S_GUARD;
            end
            // The guard cycle itself hides the CAM's one-cycle busy rise delay.
            S_GUARD: if (!cam_busy) state_d = S_COLLECT;
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_COLLECT;
            cnt_q     <= '0;
            key_q     <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            wr_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            wr_addr_q <= wr_addr_d;
            err_q     <= err_d;
        end
    end

`ifdef CAM_ENTRY_LOADER_STATS_EN
    logic [15:0] wr_cnt_q, er_cnt_q;
    assign stat_writes = wr_cnt_q;
    assign stat_errors = er_cnt_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_cnt_q <= '0;
            er_cnt_q <= '0;
        end else begin
            if (we_c && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (err_q && er_cnt_q != 16'hFFFF) er_cnt_q <= er_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cam_entry_loader.sv
// Directed self-checking bench for cam_entry_loader (stats ports when CAM_ENTRY_LOADER_STATS_EN).
module tb_cam_entry_loader;
    localparam int CW = 205;
    localparam int AB = 4;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic [AB-1:0] s_addr = '0;
    logic          s_last = 1'b0;
    logic          cam_we;
    logic [AB-1:0] cam_wr_addr;
    logic [CW-1:0] cam_din;
    logic          cam_busy = 1'b0;
    logic          err_pulse;
    logic          idle;
`ifdef CAM_ENTRY_LOADER_STATS_EN
    logic [15:0]   stat_writes, stat_errors;
`endif

    cam_entry_loader #(.C_WIDTH(CW), .ADDR_BITS(AB), .CFG_W(DW)) dut (
        .clk(clk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_addr(s_addr), .s_last(s_last), .cam_we(cam_we),
        .cam_wr_addr(cam_wr_addr), .cam_din(cam_din), .cam_busy(cam_busy),
        .err_pulse(err_pulse), .idle(idle)
`ifdef CAM_ENTRY_LOADER_STATS_EN
        , .stat_writes(stat_writes), .stat_errors(stat_errors)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int we_n = 0, err_n = 0, we_cyc = -1, busy_viol = 0;
    logic [AB-1:0] wa_q[$];
    logic [CW-1:0] wd_q[$];

    always @(negedge clk) begin
        if (aresetn) begin
            if (cam_we) begin
                we_n++;
                we_cyc = cyc;
                wa_q.push_back(cam_wr_addr);
                wd_q.push_back(cam_din);
                if (cam_busy) busy_viol++;
            end
            if (err_pulse) err_n++;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int xfer_cyc = 0;

    // Call at posedge+1; returns at posedge+1 after the beat transferred.
    task automatic send(input logic [DW-1:0] d, input logic [AB-1:0] a, input logic l);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1; s_data = d; s_addr = a; s_last = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("ready_timeout", 256'(0), 256'(1));
        @(posedge clk); #1;
        xfer_cyc = cyc;
    endtask

    task automatic idle_cycles(input int n);
        s_valid = 1'b0; s_last = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic entry(input logic [AB-1:0] a, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        send(d0, a, 1'b0);
        send(d1, a, 1'b0);
        send(d2, a, 1'b0);
        send(d3, a, 1'b1);
    endtask

    function automatic logic [CW-1:0] key4(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                           input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        logic [4*DW-1:0] w;
        w = {d3, d2, d1, d0};
        return w[CW-1:0];
    endfunction

    localparam logic [DW-1:0] D1 = 64'h1111111111111111;
    localparam logic [DW-1:0] D2 = 64'h2222222222222222;
    localparam logic [DW-1:0] D3 = 64'h3333333333333333;
    localparam logic [DW-1:0] D4 = 64'h4444444444444444;

    initial begin
        int t, ta, rdy_hi;
        logic [CW-1:0] k;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 256'(s_ready), 256'(0));
        chk("rst_idle", 256'(idle), 256'(1));
        chk("rst_we", 256'(cam_we), 256'(0));
        chk("rst_err", 256'(err_pulse), 256'(0));
        chk("rst_din", 256'(cam_din), 256'(0));
        chk("rst_addr", 256'(cam_wr_addr), 256'(0));
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 256'(s_ready), 256'(1));
        @(posedge clk); #1;

        // basic entry
        entry(4'h3, D1, D2, D3, D4);
        t = xfer_cyc;
        idle_cycles(4);
        k = cam_din;
        chk("t1_we_cnt", 256'(we_n), 256'(1));
        chk("t1_latency", 256'(we_cyc), 256'(t));
        chk("t1_addr", 256'(wa_q[0]), 256'(4'h3));
        chk("t1_din_top", 256'(k[204:192]), 256'(13'h0444));
        chk("t1_din_low", 256'(k[63:0]), 256'(D1));
        chk("t1_din_full", 256'(wd_q[0]), 256'(key4(D1, D2, D3, D4)));
        chk("t1_idle", 256'(idle), 256'(1));
        chk("t1_err", 256'(err_n), 256'(0));

        // cam_busy defers the write
        send(64'hA5A5A5A5A5A5A5A5, 4'h5, 1'b0);
        send(64'h0123456789ABCDEF, 4'h5, 1'b0);
        send(64'hFEDCBA9876543210, 4'h5, 1'b0);
        cam_busy = 1'b1;
        send(64'hFFFFFFFFFFFFFFFF, 4'h5, 1'b1);
        t = xfer_cyc;
        s_valid = 1'b0; s_last = 1'b0;
        rdy_hi = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_ready) rdy_hi++;
        end
        chk("t2_no_we_busy", 256'(we_n), 256'(1));
        chk("t2_ready_low", 256'(rdy_hi), 256'(0));
        @(posedge clk); #1;
        cam_busy = 1'b0;
        idle_cycles(4);
        chk("t2_we_cnt", 256'(we_n), 256'(2));
        chk("t2_we_cyc", 256'(we_cyc), 256'(t + 5));
        chk("t2_addr", 256'(wa_q[1]), 256'(4'h5));
        chk("t2_din", 256'(wd_q[1]), 256'(key4(64'hA5A5A5A5A5A5A5A5, 64'h0123456789ABCDEF,
                                                64'hFEDCBA9876543210, 64'hFFFFFFFFFFFFFFFF)));

        // short entry, then a normal entry
        send(64'hDEAD, 4'h2, 1'b0);
        send(64'hBEEF, 4'h2, 1'b1);
        idle_cycles(3);
        chk("t3_err", 256'(err_n), 256'(1));
        chk("t3_no_we", 256'(we_n), 256'(2));
        chk("t3_idle", 256'(idle), 256'(1));
        entry(4'h7, D4, D3, D2, D1);
        idle_cycles(4);
        chk("t3_we_cnt", 256'(we_n), 256'(3));
        chk("t3_addr", 256'(wa_q[2]), 256'(4'h7));
        chk("t3_din", 256'(wd_q[2]), 256'(key4(D4, D3, D2, D1)));

        // long entry: 6 beats
        for (int i = 0; i < 6; i++) send(64'(i + 1), 4'h9, (i == 5));
        idle_cycles(3);
        chk("t4_err", 256'(err_n), 256'(2));
        chk("t4_no_we", 256'(we_n), 256'(3));
        chk("t4_idle", 256'(idle), 256'(1));

        // back-to-back with s_valid held high
        entry(4'h0, D2, D4, D1, D3);
        ta = xfer_cyc;
        send(64'h5555555555555555, 4'hF, 1'b0);
        chk("t5_gap", 256'(xfer_cyc - ta >= 3), 256'(1));
        send(64'h6666666666666666, 4'hF, 1'b0);
        send(64'h7777777777777777, 4'hF, 1'b0);
        send(64'h8888888888888888, 4'hF, 1'b1);
        idle_cycles(4);
        chk("t5_we_cnt", 256'(we_n), 256'(5));
        chk("t5_addr_a", 256'(wa_q[3]), 256'(4'h0));
        chk("t5_din_a", 256'(wd_q[3]), 256'(key4(D2, D4, D1, D3)));
        chk("t5_addr_b", 256'(wa_q[4]), 256'(4'hF));
        chk("t5_din_b", 256'(wd_q[4]), 256'(key4(64'h5555555555555555, 64'h6666666666666666,
                                                  64'h7777777777777777, 64'h8888888888888888)));

        // reset mid-entry
        send(64'h1, 4'hB, 1'b0);
        send(64'h2, 4'hB, 1'b0);
        send(64'h3, 4'hB, 1'b0);
        aresetn = 1'b0;
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", 256'(s_ready), 256'(0));
        chk("t6_rst_idle", 256'(idle), 256'(1));
        @(posedge clk); #1;
        aresetn = 1'b1;
        idle_cycles(3);
        chk("t6_no_we", 256'(we_n), 256'(5));
        chk("t6_no_err", 256'(err_n), 256'(2));
        entry(4'hC, D3, D1, D4, D2);
        idle_cycles(4);
        chk("t6_we_cnt", 256'(we_n), 256'(6));
        chk("t6_addr", 256'(wa_q[5]), 256'(4'hC));
        chk("t6_din", 256'(wd_q[5]), 256'(key4(D3, D1, D4, D2)));
`ifdef CAM_ENTRY_LOADER_STATS_EN
        chk("t6_stat_writes", 256'(stat_writes), 256'(1));
        chk("t6_stat_errors", 256'(stat_errors), 256'(0));
`endif
        chk("we_during_busy", 256'(busy_viol), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
